// File: rtl/uart_arb_pkg.sv
// Shared constants, state encoding and index helper for the txuart request arbiter.
package uart_arb_pkg;

    localparam int NREQ_DEFAULT         = 4;
    localparam int BUSY_TIMEOUT_DEFAULT = 8;
    localparam int BYTE_W               = 8;
    localparam int IDX_W                = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_t;

    // Successor of a requester index, wrapping at n.
    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked request at or after the start index.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    localparam int SW = IDX_W + 1;

    logic [NREQ-1:0]  masked;
    logic [NREQ-1:0]  cand;
    logic [IDX_W-1:0] slot_idx [NREQ];

    assign masked = req & mask;

    // Slot gi examines requester (start + gi) mod NREQ; slot 0 has highest priority.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            logic [SW-1:0] sum;
            logic          hit;

            assign sum = {1'b0, start} + SW'(gi);
            assign slot_idx[gi] = (sum >= SW'(NREQ)) ? IDX_W'(sum - SW'(NREQ)) : sum[IDX_W-1:0];

            always_comb begin
                hit = 1'b0;
                for (int j = 0; j < NREQ; j++) begin
                    if (slot_idx[gi] == IDX_W'(j)) begin
                        hit = masked[j];
                    end
                end
            end

            assign cand[gi] = hit;
        end
    endgenerate

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                valid = 1'b1;
                index = slot_idx[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one txuart among NREQ byte requesters.
// Optional message lock (stay on one requester until its last byte) enabled by UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ         = NREQ_DEFAULT,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*BYTE_W-1:0] i_data,
    input  logic [NREQ-1:0]        i_last,
    output logic [NREQ-1:0]        o_ack,
    output logic                   o_tx_wr,
    output logic [BYTE_W-1:0]      o_tx_data,
    input  logic                   i_tx_busy,
    output logic [IDX_W-1:0]       o_grant_id,
    output logic                   o_active,
    output logic                   o_locked,
    output logic                   o_err
);

    localparam int CNT_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_t        state_reg,  state_next;
    logic [NREQ-1:0]   ack_reg,    ack_next;
    logic              wr_reg,     wr_next;
    logic [BYTE_W-1:0] data_reg,   data_next;
    logic [IDX_W-1:0]  gid_reg,    gid_next;
    logic              active_reg, active_next;
    logic              locked_reg, locked_next;
    logic              err_reg,    err_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;

    logic [NREQ-1:0]   mask;
    logic [NREQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [BYTE_W-1:0] pick_data;
    logic              pick_last;

    assign start_idx = next_index(gid_reg, NREQ);

    // While a message is locked only the owning requester may be picked.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign mask[gi]        = ~locked_reg | (gid_reg == IDX_W'(gi));
            assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (i_req),
        .mask  (mask),
        .start (start_idx),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        pick_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_data = i_data[i*BYTE_W +: BYTE_W];
                pick_last = i_last[i];
            end
        end
    end

`ifndef UART_ARB_LOCK_EN
    logic unused_last;
    assign unused_last = pick_last;
`endif

    always_comb begin
        state_next  = state_reg;
        ack_next    = '0;
        wr_next     = 1'b0;
        data_next   = data_reg;
        gid_next    = gid_reg;
        locked_next = locked_reg;
        err_next    = 1'b0;
        cnt_next    = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                // An already-busy transmitter belongs to someone else; never grant over it.
                if (pick_valid && !i_tx_busy) begin
                    state_next = ST_WAIT_BUSY;
                    ack_next   = pick_onehot;
                    wr_next    = 1'b1;
                    data_next  = pick_data;
                    gid_next   = pick_idx;
                    cnt_next   = '0;
`ifdef UART_ARB_LOCK_EN
                    locked_next = ~pick_last;
`endif
                end
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        active_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg  <= ST_IDLE;
            ack_reg    <= '0;
            wr_reg     <= 1'b0;
            data_reg   <= '0;
            gid_reg    <= IDX_W'(NREQ - 1);
            active_reg <= 1'b0;
            locked_reg <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            ack_reg    <= ack_next;
            wr_reg     <= wr_next;
            data_reg   <= data_next;
            gid_reg    <= gid_next;
            active_reg <= active_next;
            locked_reg <= locked_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign o_ack      = ack_reg;
    assign o_tx_wr    = wr_reg;
    assign o_tx_data  = data_reg;
    assign o_grant_id = gid_reg;
    assign o_active   = active_reg;
    assign o_locked   = locked_reg;
    assign o_err      = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model with a per-cycle compare plus directed literal checks.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int BT   = 8;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [NREQ-1:0]   i_req;
    logic [NREQ*8-1:0] i_data;
    logic [NREQ-1:0]   i_last;
    logic [NREQ-1:0]   o_ack;
    logic              o_tx_wr;
    logic [7:0]        o_tx_data;
    logic              i_tx_busy;
    logic [2:0]        o_grant_id;
    logic              o_active;
    logic              o_locked;
    logic              o_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ack      (o_ack),
        .o_tx_wr    (o_tx_wr),
        .o_tx_data  (o_tx_data),
        .i_tx_busy  (i_tx_busy),
        .o_grant_id (o_grant_id),
        .o_active   (o_active),
        .o_locked   (o_locked),
        .o_err      (o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-requester byte queues (the requesters' pending messages)
    logic [7:0] bd [NREQ][16];
    logic       bl [NREQ][16];
    int         hd [NREQ];
    int         tl [NREQ];

    // Model state
    int  cyc = 0;
    int  idle_cyc = 0;
    int  err_cyc = -1;
    int  rise_cyc = -1;
    int  fall_cyc = -1;
    int  tx_delay = 2;
    int  tx_len = 3;
    bit  force_busy = 1'b0;
    bit  rst_flag = 1'b1;
    logic [NREQ-1:0] e_ack = '0;
    logic            e_wr = 1'b0;
    logic [7:0]      e_data = 8'h00;
    logic [2:0]      e_gid = 3'(NREQ - 1);
    logic            e_active = 1'b0;
    logic            e_locked = 1'b0;
    logic            e_err = 1'b0;
    int              e_w = 0;

    // Observed DUT transactions
    int         wr_n = 0;
    int         ack_n = 0;
    int         err_n = 0;
    logic [7:0] wr_d [64];
    int         wr_id [64];
    int         wr_cyc [64];
    int         err_at [16];

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
        end else begin
            $display("[TB] ok %s = %0d", name, got);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        bd[r][tl[r]] = d;
        bl[r][tl[r]] = l;
        tl[r]++;
    endtask

    task automatic clear_log();
        wr_n = 0;
        ack_n = 0;
        err_n = 0;
    endtask

    task automatic tick();
        bit found;
        int w;
        @(negedge clk);
        n_tests++;
        if (o_ack !== e_ack || o_tx_wr !== e_wr || o_tx_data !== e_data || o_grant_id !== e_gid ||
            o_active !== e_active || o_locked !== e_locked || o_err !== e_err) begin
            n_fail++;
            $display("FAIL cycle %0d outputs: got ack=%b wr=%b data=%h gid=%0d act=%b lock=%b err=%b, want ack=%b wr=%b data=%h gid=%0d act=%b lock=%b err=%b",
                     cyc, o_ack, o_tx_wr, o_tx_data, o_grant_id, o_active, o_locked, o_err,
                     e_ack, e_wr, e_data, e_gid, e_active, e_locked, e_err);
        end
        if (o_tx_wr === 1'b1 && wr_n < 64) begin
            wr_d[wr_n] = o_tx_data;
            wr_id[wr_n] = int'(o_grant_id);
            wr_cyc[wr_n] = cyc;
            wr_n++;
            $display("[TB] cycle %0d write id=%0d data=%h", cyc, o_grant_id, o_tx_data);
        end
        if (o_ack !== '0) ack_n++;
        if (o_err === 1'b1 && err_n < 16) begin
            err_at[err_n] = cyc;
            err_n++;
            $display("[TB] cycle %0d busy timeout", cyc);
        end

        // The granted requester sees its ack and the transmitter starts (or never does)
        if (e_wr) begin
            hd[e_w]++;
            if (tx_delay > 0) begin
                rise_cyc = cyc + tx_delay;
                fall_cyc = rise_cyc + tx_len;
                idle_cyc = fall_cyc + 1;
                err_cyc  = -1;
            end else begin
                rise_cyc = -1;
                fall_cyc = -1;
                idle_cyc = cyc + BT;
                err_cyc  = cyc + BT;
            end
        end

        i_reset   = rst_flag;
        i_tx_busy = force_busy || (cyc >= rise_cyc && cyc < fall_cyc);
        for (int r = 0; r < NREQ; r++) begin
            i_req[r]         = (hd[r] != tl[r]);
            i_data[8*r +: 8] = (hd[r] != tl[r]) ? bd[r][hd[r]] : 8'h00;
            i_last[r]        = (hd[r] != tl[r]) ? bl[r][hd[r]] : 1'b0;
        end

        e_ack = '0;
        e_wr  = 1'b0;
        e_err = 1'b0;
        if (rst_flag) begin
            e_data   = 8'h00;
            e_gid    = 3'(NREQ - 1);
            e_active = 1'b0;
            e_locked = 1'b0;
            idle_cyc = 0;
            err_cyc  = -1;
            rise_cyc = -1;
            fall_cyc = -1;
        end else begin
            e_err    = (cyc + 1 == err_cyc);
            e_active = (cyc + 1 < idle_cyc);
            if (cyc >= idle_cyc && !i_tx_busy) begin
                found = 1'b0;
                w = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (int'(e_gid) + k) % NREQ;
                    if (!found && hd[c] != tl[c] && (!e_locked || c == int'(e_gid))) begin
                        found = 1'b1;
                        w = c;
                    end
                end
                if (found) begin
                    e_wr     = 1'b1;
                    e_ack[w] = 1'b1;
                    e_data   = bd[w][hd[w]];
                    e_gid    = 3'(w);
                    e_active = 1'b1;
                    e_w      = w;
`ifdef UART_ARB_LOCK_EN
                    e_locked = !bl[w][hd[w]];
`endif
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [7:0] seq37 [3];
        for (int r = 0; r < NREQ; r++) begin
            hd[r] = 0;
            tl[r] = 0;
        end
        i_reset = 1'b1;
        i_req = '0;
        i_data = '0;
        i_last = '0;
        i_tx_busy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        run(2);
        rst_flag = 1'b0;
        check("reset grant_id", int'(o_grant_id), NREQ - 1);
        check("reset active", int'(o_active), 0);
        check("reset tx_wr", int'(o_tx_wr), 0);
        check("reset tx_data", int'(o_tx_data), 0);
        check("reset ack", int'(o_ack), 0);
        check("reset err", int'(o_err), 0);
        check("reset locked", int'(o_locked), 0);

        // All four requesters held: round robin 0,1,2,3,0,1,2,3
        tx_delay = 1; tx_len = 3;
        clear_log();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < NREQ; r++) push(r, 8'(8'h10 + r), 1'b1);
        run(70);
        check("rr write count", wr_n, 8);
        check("rr ack count", ack_n, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rr grant %0d id", i), wr_id[i], i % 4);
            check($sformatf("rr grant %0d data", i), int'(wr_d[i]), 'h10 + i % 4);
        end
        for (int i = 1; i < 8; i++)
            check($sformatf("rr spacing ok %0d", i), int'(wr_cyc[i] - wr_cyc[i-1] >= 3), 1);

        // Single requester, long transmission
        tx_delay = 2; tx_len = 100;
        clear_log();
        push(0, 8'h41, 1'b1);
        run(115);
        check("single write count", wr_n, 1);
        check("single ack count", ack_n, 1);
        check("single data", int'(wr_d[0]), 'h41);
        check("single id", wr_id[0], 0);
        check("single idle after", int'(o_active), 0);

        // Busy never rises: timeout, then next requester
        tx_delay = 0;
        clear_log();
        push(1, 8'h55, 1'b1);
        push(2, 8'h66, 1'b1);
        run(30);
        check("timeout write count", wr_n, 2);
        check("timeout err count", err_n, 2);
        check("timeout first id", wr_id[0], 1);
        check("timeout second id", wr_id[1], 2);
        check("timeout err delay", err_at[0] - wr_cyc[0], BT);
        check("timeout regrant delay", wr_cyc[1] - err_at[0], 1);

        // Busy already high in IDLE: no grant until it falls
        tx_delay = 1; tx_len = 3;
        force_busy = 1'b1;
        clear_log();
        for (int r = 0; r < NREQ; r++) push(r, 8'(8'hA0 + r), 1'b1);
        run(20);
        check("ext busy writes", wr_n, 0);
        check("ext busy acks", ack_n, 0);
        force_busy = 1'b0;
        run(35);
        check("after busy writes", wr_n, 4);
        check("after busy first id", wr_id[0], 3);

        // Message lock scenario
        push(1, 8'h31, 1'b1);
        run(12);
        clear_log();
        push(0, 8'h00, 1'b1);
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b1);
        run(30);
`ifdef UART_ARB_LOCK_EN
        seq37[0] = 8'h20; seq37[1] = 8'h21; seq37[2] = 8'h00;
`else
        seq37[0] = 8'h20; seq37[1] = 8'h00; seq37[2] = 8'h21;
`endif
        check("lock write count", wr_n, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("lock seq %0d", i), int'(wr_d[i]), int'(seq37[i]));

        // Reset during WAIT_DONE
        tx_delay = 1; tx_len = 50;
        push(3, 8'h77, 1'b1);
        run(8);
        check("pre-reset active", int'(o_active), 1);
        clear_log();
        rst_flag = 1'b1;
        tick();
        rst_flag = 1'b0;
        tick();
        check("post-reset active", int'(o_active), 0);
        check("post-reset grant_id", int'(o_grant_id), NREQ - 1);
        check("post-reset data", int'(o_tx_data), 0);
        run(20);
        check("post-reset acks", ack_n, 0);
        check("post-reset errs", err_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one txuart transmitter, range 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 8: cycles allowed for i_tx_busy to rise after o_tx_wr.
REQ-003 i_clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  NREQ  per-requester byte-pending flag; held high until acknowledged.
REQ-006 i_data  input  NREQ*8  per-requester byte; requester n occupies bits [8n+7:8n]; stable while i_req[n] high.
REQ-007 i_last  input  NREQ  per-requester last-byte-of-message flag; qualified by i_req.
REQ-008 o_ack  output  NREQ  one-cycle pulse: the byte of requester n has been taken.
REQ-009 o_tx_wr  output  1  one-cycle write strobe to txuart i_wr.
REQ-010 o_tx_data  output  8  byte to txuart i_data; held stable from o_tx_wr until return to IDLE.
REQ-011 i_tx_busy  input  1  txuart o_busy.
REQ-012 o_grant_id  output  3  index of the requester last granted.
REQ-013 o_active  output  1  high whenever state is not IDLE.
REQ-014 o_locked  output  1  message lock held (see Configuration).
REQ-015 o_err  output  1  one-cycle pulse on busy timeout.

Function
REQ-016 States: IDLE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-017 IDLE: if some i_req bit is high and i_tx_busy is low, on that edge select winner w, set o_ack[w]=1, o_tx_wr=1, o_tx_data=byte w, o_grant_id=w, and go to WAIT_BUSY; otherwise remain in IDLE.
REQ-018 Latency: request sampled at edge k -> o_ack and o_tx_wr high in the cycle after edge k, both for exactly one cycle.
REQ-019 Winner selection: round-robin, search starting at (o_grant_id+1) mod NREQ; after reset the search starts at index 0.
REQ-020 A requester shall not be acknowledged more than once per transfer; o_ack is onehot or zero.
REQ-021 WAIT_BUSY: on i_tx_busy=1 go to WAIT_DONE; if i_tx_busy stays 0 for BUSY_TIMEOUT cycles, pulse o_err and go to IDLE.
REQ-022 WAIT_DONE: on i_tx_busy=0 go to IDLE; no timeout applies in WAIT_DONE.
REQ-023 In IDLE with i_tx_busy already high (external break or other user), no grant shall be issued.
REQ-024 Requests arriving while not IDLE are ignored until return to IDLE; no request shall be lost while i_req is held.
REQ-025 Minimum spacing between o_tx_wr pulses shall be 3 cycles.

Reset
REQ-026 Reset shall set state=IDLE, o_ack=0, o_tx_wr=0, o_tx_data=0, o_grant_id=NREQ-1 (so the first search starts at 0), o_active=0, o_locked=0, o_err=0, and clear the timeout counter.
REQ-027 Reset mid-transfer shall abandon the transfer without issuing o_ack or o_err; the txuart is reset by the same signal.

Configuration
REQ-028 Macro UART_ARB_LOCK_EN: when defined, a grant with i_last[w]=0 shall set o_locked and mask all requesters except w until a granted byte from w has i_last=1, which clears o_locked on that grant edge.
REQ-029 With UART_ARB_LOCK_EN, while locked and i_req[w] is low, the arbiter shall idle (no grant to others).
REQ-030 Without UART_ARB_LOCK_EN, i_last shall be ignored, o_locked shall be tied to 0, and arbitration shall be per byte.

Structure
REQ-031 Package uart_arb_pkg shall hold the state encoding, NREQ and BUSY_TIMEOUT defaults, and the byte-width constant (8).
REQ-032 Sub-module rr_pick: combinational round-robin picker (request vector, start index, mask -> valid, index); it is the only sub-module.

Verification
REQ-033 Single requester: i_req=0001, i_data[7:0]=0x41, busy rises 2 cycles after wr and falls after 100 cycles -> one o_ack[0] pulse, o_tx_wr with o_tx_data=0x41, return to IDLE on busy fall.
REQ-034 All four requesters held high, bytes 0x10..0x13 -> grant order 0,1,2,3,0,...; each o_ack is onehot.
REQ-035 i_tx_busy never rises after o_tx_wr -> o_err pulses exactly BUSY_TIMEOUT cycles later and the next request is granted.
REQ-036 i_tx_busy high in IDLE with i_req=1111 -> no o_ack or o_tx_wr until busy falls.
REQ-037 UART_ARB_LOCK_EN defined: requester 2 sends 0x20/last=0, 0x21/last=1 while requester 0 is held high -> 0x20, 0x21, then 0x00; without the macro -> 0x20, 0x00, 0x21.
REQ-038 Reset asserted in WAIT_DONE -> all outputs at reset values on the next cycle and no o_ack or o_err.
